serial_subtractor: RTL

- Bit-serial subtractor computing a − b one bit per clock, LSB first, with a single registered borrow flip-flop.
- It is the inverse operation to the team's combinational ripple-carry adder, traded for area: one full-subtractor cell plus shift registers instead of WIDTH cells.
- It sits behind a valid/ready handshake on both the operand and result sides, so it can be dropped into datapaths that already stream operands to the adder.

---
 rtl/serial_subtractor.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, valid/ready on both sides.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              br_q, br_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              borrow_q, borrow_d;
    logic              bit_d;
    logic              br_next;
`ifdef SERIAL_SUB_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // Single full-subtractor cell on the current LSBs.
    always_comb begin
        bit_d   = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // The vacated MSB of the minuend register accumulates the difference bits, so
                // the published result only changes once the whole word is complete.
                a_d  = {bit_d, a_q[WIDTH-1:1]};
                b_d  = {1'b0, b_q[WIDTH-1:1]};
                br_d = br_next;
                if (cnt_q == CntLast) begin
                    state_d  = StDone;
                    diff_d   = {bit_d, a_q[WIDTH-1:1]};
                    borrow_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = br_q ^ br_next;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    assign in_ready   = (state_q == StIdle);
    assign out_valid  = (state_q == StDone);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule
